// File: rtl/ttt_board_referee.sv
// Tic-tac-toe board keeper and rules referee: validates keypad moves, writes the
// 3x3 board, then walks the eight winning lines one per cycle to flag win/draw.
module ttt_board_referee #(
  parameter int SCAN_LINES = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        player_play,
  input  logic        computer_play,
  input  logic        kphit,
  input  logic [3:0]  key,
  output logic        illegal_move,
  output logic        win,
  output logic [1:0]  winner,
  output logic        no_space,
  output logic        busy,
  output logic [17:0] board,
  output logic [3:0]  move_count
);

  typedef enum logic [1:0] {READY, SCAN, DONE} state_t;

  state_t      state, state_next;
  logic [1:0]  cells [9];
  logic [2:0]  scan_idx;
  logic [1:0]  mark_q;
  logic        kphit_q;

  logic        mover_valid;
  logic [1:0]  mark;
  logic        key_ok;
  logic [1:0]  target;
  logic        accept;
  logic [1:0]  la, lb, lc;
  logic        line_hit;
  logic        last_line;

  assign mover_valid = player_play ^ computer_play;
  assign mark        = player_play ? 2'b01 : 2'b10;
  assign key_ok      = (key >= 4'd1) && (key <= 4'd9);

  always_comb begin
    target = 2'b00;
    for (int i = 0; i < 9; i++)
      if (key == 4'(i + 1)) target = cells[i];
  end

  assign illegal_move = (state != READY) || !mover_valid || !key_ok || (target != 2'b00);
  assign accept       = kphit && !kphit_q && !illegal_move;

  // Line order: rows, columns, main diagonal, anti-diagonal (cells 0-based).
  always_comb begin
    la = 2'b00;
    lb = 2'b00;
    lc = 2'b00;
    case (scan_idx)
      3'd0: begin la = cells[0]; lb = cells[1]; lc = cells[2]; end
      3'd1: begin la = cells[3]; lb = cells[4]; lc = cells[5]; end
      3'd2: begin la = cells[6]; lb = cells[7]; lc = cells[8]; end
      3'd3: begin la = cells[0]; lb = cells[3]; lc = cells[6]; end
      3'd4: begin la = cells[1]; lb = cells[4]; lc = cells[7]; end
      3'd5: begin la = cells[2]; lb = cells[5]; lc = cells[8]; end
      3'd6: begin la = cells[0]; lb = cells[4]; lc = cells[8]; end
      default: begin la = cells[2]; lb = cells[4]; lc = cells[6]; end
    endcase
  end

  assign line_hit  = (la == mark_q) && (lb == mark_q) && (lc == mark_q);
  assign last_line = (scan_idx == 3'(SCAN_LINES - 1));

  always_comb begin
    state_next = state;
    case (state)
      READY:   if (accept) state_next = SCAN;
      SCAN: begin
        if (line_hit)       state_next = DONE;
        else if (last_line) state_next = (move_count == 4'd9) ? DONE : READY;
      end
      default: state_next = DONE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= READY;
    else          state <= state_next;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 9; i++) cells[i] <= 2'b00;
      scan_idx   <= 3'd0;
      mark_q     <= 2'b00;
      kphit_q    <= 1'b0;
      move_count <= 4'd0;
      win        <= 1'b0;
      winner     <= 2'b00;
      no_space   <= 1'b0;
    end else begin
      kphit_q <= kphit;
      if (accept) begin
        for (int i = 0; i < 9; i++)
          if (key == 4'(i + 1)) cells[i] <= mark;
        mark_q   <= mark;
        scan_idx <= 3'd0;
        if (move_count != 4'd9) move_count <= move_count + 4'd1;
      end
      if (state == SCAN) begin
        scan_idx <= scan_idx + 3'd1;
        if (line_hit) begin
          win      <= 1'b1;
          winner   <= mark_q;
          no_space <= (move_count == 4'd9);
        end else if (last_line && move_count == 4'd9) begin
          no_space <= 1'b1;
        end
      end
    end
  end

  assign busy = (state == SCAN);

  for (genvar gi = 0; gi < 9; gi++) begin : g_board
    assign board[2*gi+1:2*gi] = cells[gi];
  end

endmodule

// File: tb/tb_ttt_board_referee.sv
// Scoreboard bench for ttt_board_referee: a reference board model predicts each
// move's outcome and scan length; results are compared when the scan ends.
module tb_ttt_board_referee;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        player_play, computer_play, kphit;
  logic [3:0]  key;
  logic        illegal_move, win, no_space, busy;
  logic [1:0]  winner;
  logic [17:0] board;
  logic [3:0]  move_count;

  ttt_board_referee dut (
    .clk(clk), .reset_n(reset_n), .player_play(player_play), .computer_play(computer_play),
    .kphit(kphit), .key(key), .illegal_move(illegal_move), .win(win), .winner(winner),
    .no_space(no_space), .busy(busy), .board(board), .move_count(move_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic        illegal;
    logic [17:0] board;
    logic [3:0]  mc;
    logic        win;
    logic [1:0]  winner;
    logic        nospace;
    int          busy_cycles;
  } exp_t;

  exp_t sb[$];

  // Reference model state
  logic [1:0] m_cell [9];
  int         m_mc;
  logic       m_done, m_win, m_nospace;
  logic [1:0] m_winner;
  int         lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                               '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  function automatic logic [17:0] m_board();
    logic [17:0] b = '0;
    for (int i = 0; i < 9; i++) b[2*i +: 2] = m_cell[i];
    return b;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 9; i++) m_cell[i] = 2'b00;
    m_mc = 0; m_done = 0; m_win = 0; m_nospace = 0; m_winner = 2'b00;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; player_play = 0; computer_play = 0; kphit = 0; key = 4'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  // who: 0 = player X, 1 = computer O, 2 = both enables, 3 = neither
  task automatic do_move(input int who, input int k, input string tag);
    exp_t e, got_e;
    logic [1:0] mark;
    logic ill;
    int hit, n;
    @(negedge clk);
    player_play   = (who == 0 || who == 2);
    computer_play = (who == 1 || who == 2);
    key   = 4'(k);
    kphit = 1'b0;
    mark  = (who == 0) ? 2'b01 : 2'b10;
    ill   = m_done || (who > 1) || (k < 1) || (k > 9);
    if (!ill) ill = (m_cell[k-1] != 2'b00);
    e.busy_cycles = 0;
    if (!ill) begin
      m_cell[k-1] = mark;
      m_mc++;
      hit = -1;
      for (int l = 0; l < 8; l++)
        if (hit < 0 && m_cell[lines[l][0]] == mark && m_cell[lines[l][1]] == mark &&
            m_cell[lines[l][2]] == mark) hit = l;
      if (hit >= 0) begin
        m_win = 1; m_winner = mark; m_done = 1; m_nospace = (m_mc == 9);
        e.busy_cycles = hit + 1;
      end else begin
        e.busy_cycles = 8;
        if (m_mc == 9) begin m_nospace = 1; m_done = 1; end
      end
    end
    e.illegal = ill; e.board = m_board(); e.mc = 4'(m_mc);
    e.win = m_win; e.winner = m_winner; e.nospace = m_nospace;
    sb.push_back(e);

    @(posedge clk);
    @(negedge clk);
    check_eq({tag, "/illegal"}, 32'(illegal_move), 32'(ill));
    kphit = 1'b1;
    @(posedge clk);
    n = 0;
    @(negedge clk);
    if (!ill) begin
      while (busy && n < 20) begin
        n++;
        @(negedge clk);
      end
    end else begin
      repeat (2) @(negedge clk);
    end
    got_e = sb.pop_front();
    check_eq({tag, "/busy_cycles"}, 32'(n), 32'(got_e.busy_cycles));
    check_eq({tag, "/board"}, 32'(board), 32'(got_e.board));
    check_eq({tag, "/move_count"}, 32'(move_count), 32'(got_e.mc));
    check_eq({tag, "/win"}, 32'(win), 32'(got_e.win));
    check_eq({tag, "/winner"}, 32'(winner), 32'(got_e.winner));
    check_eq({tag, "/no_space"}, 32'(no_space), 32'(got_e.nospace));
    $display("move %s who=%0d key=%0d board=%05h mc=%0d win=%0b nsp=%0b", tag, who, k, board,
             move_count, win, no_space);
    kphit = 1'b0;
  endtask

  initial begin
    do_reset();
    @(negedge clk);
    check_eq("reset/board", 32'(board), 32'd0);
    check_eq("reset/move_count", 32'(move_count), 32'd0);
    check_eq("reset/flags", {28'd0, win, winner, no_space}, 32'd0);
    check_eq("reset/busy", 32'(busy), 32'd0);
    check_eq("reset/illegal_no_mover", 32'(illegal_move), 32'd1);

    // Legal move, occupied cell, bad keys, bad enables
    do_move(0, 5, "x5");
    check_eq("x5/cell5", 32'(board[9:8]), 32'd1);
    do_move(1, 5, "o5_occupied");
    do_move(1, 0, "key0");
    do_move(1, 12, "key12");
    do_move(2, 1, "both_enables");
    do_move(3, 1, "no_enable");

    // Early-exit win on line 0
    do_reset();
    do_move(0, 1, "w_x1");
    do_move(1, 4, "w_o4");
    do_move(0, 2, "w_x2");
    do_move(1, 5, "w_o5");
    do_move(0, 3, "w_x3");
    do_move(1, 9, "w_after_done");

    // Full-board draw
    do_reset();
    do_move(0, 1, "d_x1"); do_move(1, 2, "d_o2"); do_move(0, 3, "d_x3");
    do_move(1, 5, "d_o5"); do_move(0, 4, "d_x4"); do_move(1, 6, "d_o6");
    do_move(0, 8, "d_x8"); do_move(1, 7, "d_o7"); do_move(0, 9, "d_x9");
    check_eq("draw/board_const", 32'(board), 32'(18'b01_01_10_10_10_01_01_10_01));
    do_move(0, 1, "d_after_done");

    // Held kphit plus a second rising edge during SCAN
    do_reset();
    @(negedge clk);
    player_play = 1; key = 4'd5; kphit = 0;
    @(posedge clk);
    @(negedge clk);
    kphit = 1;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    kphit = 0;
    @(negedge clk);
    kphit = 1; key = 4'd1;
    repeat (20) @(negedge clk);
    check_eq("held/move_count", 32'(move_count), 32'd1);
    check_eq("held/board", 32'(board), 32'(18'b01 << 8));
    check_eq("held/busy", 32'(busy), 32'd0);
    check_eq("held/illegal_ready", 32'(illegal_move), 32'd0);
    $display("held board=%05h mc=%0d", board, move_count);
    kphit = 0;

    // Asynchronous reset mid-scan
    do_reset();
    @(negedge clk);
    player_play = 1; key = 4'd3; kphit = 0;
    @(posedge clk);
    @(negedge clk);
    kphit = 1;
    @(posedge clk);
    repeat (4) @(negedge clk);
    check_eq("rst_scan/busy_before", 32'(busy), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check_eq("rst_scan/board", 32'(board), 32'd0);
    check_eq("rst_scan/move_count", 32'(move_count), 32'd0);
    check_eq("rst_scan/busy", 32'(busy), 32'd0);
    $display("rst_scan board=%05h mc=%0d busy=%0b", board, move_count, busy);
    @(negedge clk);
    kphit = 0; player_play = 0;
    reset_n = 1'b1;
    model_reset();
    do_move(0, 9, "after_rst_x9");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
